// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: ALU operation codes, forward and
// operand-select encodings, and the multiplier FSM state type.
package ex_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_MOVB = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;

    localparam logic [1:0] FWD_BASE = 2'd0;
    localparam logic [1:0] FWD_MEM  = 2'd1;
    localparam logic [1:0] FWD_WB   = 2'd2;
    localparam logic [1:0] FWD_ZERO = 2'd3;

    localparam logic [1:0] SRC_A_BR      = 2'd0;
    localparam logic [1:0] SRC_A_OUTSIDE = 2'd1;
    localparam logic [1:0] SRC_A_PC      = 2'd2;
    localparam logic [1:0] SRC_A_ZERO    = 2'd3;

    localparam logic [1:0] SRC_B_SEXT = 2'd0;
    localparam logic [1:0] SRC_B_ZEXT = 2'd1;
    localparam logic [1:0] SRC_B_AR   = 2'd2;
    localparam logic [1:0] SRC_B_ZERO = 2'd3;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } mul_state_t;

endpackage

// File: rtl/alu_w.sv
// Combinational ALU of the execute stage.
// Ports: op (operation code), a/b (operands), result, szcv (S,Z,C,V flags).
// C is the carry for ADD and the borrow for SUB; C and V are 0 otherwise.
module alu_w
    import ex_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       szcv
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    logic           carry;
    logic           overflow;

    assign sum  = {1'b0, a} + {1'b0, b};
    // The extra top bit of the difference is the borrow out.
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        result   = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        case (op)
            ALU_ADD: begin
                result   = sum[WIDTH-1:0];
                carry    = sum[WIDTH];
                overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB: begin
                result   = diff[WIDTH-1:0];
                carry    = diff[WIDTH];
                overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_MOVB: result = b;
            ALU_SLL:  result = a << b[3:0];
            ALU_SRL:  result = a >> b[3:0];
            default:  result = '0;
        endcase
        szcv = {result[WIDTH-1], (result == '0), carry, overflow};
    end

endmodule

// File: rtl/execute_mc_p4.sv
// Execute stage with operand forwarding, a registered EX/MEM output using a
// valid/ready handshake, and an iterative shift-add multiplier that stalls
// upstream while it runs.
// Ports:
//   clock, reset (synchronous, active-low)
//   in_valid / ready          : ID/EX handshake
//   stall_in                  : downstream back-pressure on ex_result
//   op_*                      : decoded control (forward selects, operand
//                               selects, ALU op, multiply, output update)
//   ar, br, pc_pre, outside_input, instruction_register : operands
//   data_mem_fwd, data_wb_fwd : forwarded values from MEM and WB
//   ex_result, mul_hi, ex_valid, cond : registered results
//   ar_fwd                    : forwarded ar (store data), combinational
//   data_for_output           : output port register
//   busy                      : multiplier running
//
// state | meaning
// IDLE  | accepting instructions, ALU ops finish in one cycle
// MUL   | shift-add iterations in progress, upstream stalled
module execute_mc_p4
    import ex_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int IMM_WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             ready,
    input  logic             stall_in,
    input  logic [1:0]       op_forward_a,
    input  logic [1:0]       op_forward_b,
    input  logic [1:0]       op_forward_c,
    input  logic [1:0]       op_alu_src_a,
    input  logic [1:0]       op_alu_src_b,
    input  logic [3:0]       op_alu,
    input  logic             op_mul,
    input  logic             op_output_update,
    input  logic [WIDTH-1:0] ar,
    input  logic [WIDTH-1:0] br,
    input  logic [WIDTH-1:0] pc_pre,
    input  logic [WIDTH-1:0] outside_input,
    input  logic [15:0]      instruction_register,
    input  logic [WIDTH-1:0] data_mem_fwd,
    input  logic [WIDTH-1:0] data_wb_fwd,
    output logic [WIDTH-1:0] ex_result,
    output logic [WIDTH-1:0] mul_hi,
    output logic             ex_valid,
    output logic [3:0]       cond,
    output logic [WIDTH-1:0] ar_fwd,
    output logic [WIDTH-1:0] data_for_output,
    output logic             busy
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    mul_state_t state;
    mul_state_t state_next;

    logic [WIDTH-1:0]   src_a;
    logic [WIDTH-1:0]   src_b;
    logic [WIDTH-1:0]   alu_a;
    logic [WIDTH-1:0]   alu_b;
    logic [WIDTH-1:0]   imm_sext;
    logic [WIDTH-1:0]   alu_result;
    logic [3:0]         alu_szcv;
    logic               accept;
    logic               mul_done;

    logic [WIDTH-1:0]   mul_a;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_next;
    logic [WIDTH:0]     partial;
    logic [CNT_W-1:0]   iter_cnt;

    logic               unused_ir;

    // Only the low bits of the instruction feed the datapath.
    assign unused_ir = ^instruction_register;

    assign imm_sext = WIDTH'($signed(instruction_register[IMM_WIDTH-1:0]));

    always_comb begin
        src_a = '0;
        case (op_alu_src_a)
            SRC_A_BR:      src_a = br;
            SRC_A_OUTSIDE: src_a = outside_input;
            SRC_A_PC:      src_a = pc_pre;
            default:       src_a = '0;
        endcase

        src_b = '0;
        case (op_alu_src_b)
            SRC_B_SEXT: src_b = imm_sext;
            SRC_B_ZEXT: src_b = WIDTH'(instruction_register[3:0]);
            SRC_B_AR:   src_b = ar;
            default:    src_b = '0;
        endcase

        alu_a = '0;
        case (op_forward_a)
            FWD_BASE: alu_a = src_a;
            FWD_MEM:  alu_a = data_mem_fwd;
            FWD_WB:   alu_a = data_wb_fwd;
            default:  alu_a = '0;
        endcase

        alu_b = '0;
        case (op_forward_b)
            FWD_BASE: alu_b = src_b;
            FWD_MEM:  alu_b = data_mem_fwd;
            FWD_WB:   alu_b = data_wb_fwd;
            default:  alu_b = '0;
        endcase

        ar_fwd = '0;
        case (op_forward_c)
            FWD_BASE: ar_fwd = ar;
            FWD_MEM:  ar_fwd = data_mem_fwd;
            FWD_WB:   ar_fwd = data_wb_fwd;
            default:  ar_fwd = '0;
        endcase
    end

    alu_w #(.WIDTH(WIDTH)) u_alu (
        .op     (op_alu),
        .a      (alu_a),
        .b      (alu_b),
        .result (alu_result),
        .szcv   (alu_szcv)
    );

    assign ready  = !busy && !(ex_valid && stall_in);
    assign accept = in_valid && ready;

    // One shift-add step: the multiplier occupies the low half of prod and is
    // consumed LSB first while partial sums accumulate into the high half.
    assign partial   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mul_a} : '0);
    assign prod_next = {partial, prod[WIDTH-1:1]};

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        mul_done   = 1'b0;
        case (state)
            IDLE: begin
                if (accept && op_mul) begin
                    state_next = MUL;
                end
            end
            MUL: begin
                busy = 1'b1;
                if (iter_cnt == '0) begin
                    state_next = IDLE;
                    mul_done   = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            ex_result       <= '0;
            mul_hi          <= '0;
            cond            <= '0;
            ex_valid        <= 1'b0;
            data_for_output <= '0;
            mul_a           <= '0;
            prod            <= '0;
            iter_cnt        <= '0;
        end else begin
            if (op_output_update) begin
                data_for_output <= ar_fwd;
            end

            if (busy) begin
                prod     <= prod_next;
                iter_cnt <= iter_cnt - 1'b1;
            end

            if (mul_done) begin
                ex_result <= prod_next[WIDTH-1:0];
                mul_hi    <= prod_next[2*WIDTH-1:WIDTH];
                cond      <= {prod_next[WIDTH-1], (prod_next[WIDTH-1:0] == '0), 2'b00};
                ex_valid  <= 1'b1;
            end else if (accept && !op_mul) begin
                ex_result <= alu_result;
                cond      <= alu_szcv;
                ex_valid  <= 1'b1;
            end else begin
                if (accept) begin
                    // Operands are captured here so forwarding changes while
                    // the multiply runs cannot disturb it.
                    mul_a    <= alu_a;
                    prod     <= {{WIDTH{1'b0}}, alu_b};
                    iter_cnt <= CNT_W'(WIDTH - 1);
                end
                if (!stall_in) begin
                    ex_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_execute_mc_p4.sv
module tb_execute_mc_p4;

    localparam int W = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          ready;
    logic          stall_in = 1'b0;
    logic [1:0]    op_forward_a = '0, op_forward_b = '0, op_forward_c = '0;
    logic [1:0]    op_alu_src_a = '0, op_alu_src_b = '0;
    logic [3:0]    op_alu = '0;
    logic          op_mul = 1'b0;
    logic          op_output_update = 1'b0;
    logic [W-1:0]  ar = '0, br = '0, pc_pre = '0, outside_input = '0;
    logic [15:0]   instruction_register = '0;
    logic [W-1:0]  data_mem_fwd = '0, data_wb_fwd = '0;
    logic [W-1:0]  ex_result, mul_hi, ar_fwd, data_for_output;
    logic          ex_valid, busy;
    logic [3:0]    cond;

    execute_mc_p4 #(.WIDTH(W), .IMM_WIDTH(8)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .ready(ready),
        .stall_in(stall_in), .op_forward_a(op_forward_a), .op_forward_b(op_forward_b),
        .op_forward_c(op_forward_c), .op_alu_src_a(op_alu_src_a), .op_alu_src_b(op_alu_src_b),
        .op_alu(op_alu), .op_mul(op_mul), .op_output_update(op_output_update),
        .ar(ar), .br(br), .pc_pre(pc_pre), .outside_input(outside_input),
        .instruction_register(instruction_register), .data_mem_fwd(data_mem_fwd),
        .data_wb_fwd(data_wb_fwd), .ex_result(ex_result), .mul_hi(mul_hi),
        .ex_valid(ex_valid), .cond(cond), .ar_fwd(ar_fwd),
        .data_for_output(data_for_output), .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] res;
        logic [15:0] hi;
        logic [3:0]  cond;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [15:0] last_hi = '0;
    bit          stall_rand = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] fwd_val(input logic [1:0] sel, input logic [15:0] base);
        case (sel)
            2'd0:    return base;
            2'd1:    return data_mem_fwd;
            2'd2:    return data_wb_fwd;
            default: return 16'h0;
        endcase
    endfunction

    // Reference model: the expected architectural result of the instruction
    // currently on the inputs.
    function automatic exp_t model();
        exp_t        e;
        logic [15:0] a, b, sa, sbv, imm;
        logic [7:0]  imm8;
        logic [31:0] p;
        int unsigned u;
        int          s;
        logic        c, v;
        imm8 = instruction_register[7:0];
        imm  = {{8{imm8[7]}}, imm8};
        case (op_alu_src_a)
            2'd0: sa = br;
            2'd1: sa = outside_input;
            2'd2: sa = pc_pre;
            default: sa = 16'h0;
        endcase
        case (op_alu_src_b)
            2'd0: sbv = imm;
            2'd1: sbv = {12'h0, instruction_register[3:0]};
            2'd2: sbv = ar;
            default: sbv = 16'h0;
        endcase
        a = fwd_val(op_forward_a, sa);
        b = fwd_val(op_forward_b, sbv);
        c = 1'b0;
        v = 1'b0;
        if (op_mul) begin
            p      = {16'h0, a} * {16'h0, b};
            e.res  = p[15:0];
            e.hi   = p[31:16];
            e.cond = {p[15], p[15:0] == 16'h0, 2'b00};
            return e;
        end
        case (op_alu)
            4'b0000: begin
                u = int'(a) + int'(b);
                e.res = u[15:0];
                c = (u > 32'hFFFF);
                s = int'($signed(a)) + int'($signed(b));
                v = (s > 32767) || (s < -32768);
            end
            4'b0001: begin
                e.res = a - b;
                c = (a < b);
                s = int'($signed(a)) - int'($signed(b));
                v = (s > 32767) || (s < -32768);
            end
            4'b0010: e.res = a & b;
            4'b0011: e.res = a | b;
            4'b0100: e.res = a ^ b;
            4'b0110: e.res = b;
            4'b1000: e.res = a << b[3:0];
            4'b1001: e.res = a >> b[3:0];
            default: e.res = 16'h0;
        endcase
        e.hi   = last_hi;
        e.cond = {e.res[15], e.res == 16'h0, c, v};
        return e;
    endfunction

    // Present the current inputs with in_valid until accepted; records the
    // expected result at the acceptance point.
    task automatic issue(output int tries);
        bit   acc;
        exp_t e;
        acc      = 1'b0;
        tries    = 0;
        in_valid = 1'b1;
        while (!acc && tries < 60) begin
            @(negedge clock);
            tries++;
            if (ready === 1'b1) begin
                acc = 1'b1;
                e   = model();
                if (op_mul) last_hi = e.hi;
                sb.push_back(e);
            end
            @(posedge clock);
            #2;
        end
        in_valid = 1'b0;
        if (!acc) check("accept_timeout", 32'(tries), 32'd0);
    endtask

    task automatic rand_ops();
        op_mul               = ($urandom_range(0, 7) == 0);
        op_alu               = 4'($urandom);
        op_forward_a         = 2'($urandom);
        op_forward_b         = 2'($urandom);
        op_forward_c         = 2'($urandom);
        op_alu_src_a         = 2'($urandom);
        op_alu_src_b         = 2'($urandom);
        op_output_update     = 1'($urandom);
        ar                   = 16'($urandom);
        br                   = 16'($urandom);
        pc_pre               = 16'($urandom);
        outside_input        = 16'($urandom);
        instruction_register = 16'($urandom);
        data_mem_fwd         = 16'($urandom);
        data_wb_fwd          = 16'($urandom);
    endtask

    initial begin
        forever begin
            @(posedge clock);
            #2;
            if (stall_rand) stall_in = ($urandom_range(0, 3) == 0);
        end
    end

    // Monitor: a result transfers on any edge where ex_valid && !stall_in.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset === 1'b1 && ex_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got %h with nothing expected", ex_result);
                end else if (stall_in === 1'b1) begin
                    checks++;
                    if (ex_result !== sb[0].res || cond !== sb[0].cond) begin
                        errors++;
                        $display("FAIL held_result: got %h/%h expected %h/%h",
                                 ex_result, cond, sb[0].res, sb[0].cond);
                    end
                end else begin
                    e = sb.pop_front();
                    checks++;
                    if (ex_result !== e.res || mul_hi !== e.hi || cond !== e.cond) begin
                        errors++;
                        $display("FAIL result: got res=%h hi=%h cond=%b expected res=%h hi=%h cond=%b",
                                 ex_result, mul_hi, cond, e.res, e.hi, e.cond);
                    end
                end
            end
        end
    end

    initial begin
        int t;
        int n;
        repeat (2) @(posedge clock);
        #2;
        check("reset_ex_result", 32'(ex_result), 32'h0);
        check("reset_ex_valid", 32'(ex_valid), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_cond", 32'(cond), 32'h0);
        reset = 1'b1;
        @(posedge clock);
        #2;

        // ADD with sign-extended 0xFF
        op_alu = 4'b0000; op_mul = 1'b0; op_alu_src_a = 2'd0; op_alu_src_b = 2'd0;
        br = 16'h0003; instruction_register = 16'h00FF;
        issue(t);
        check("add_sext_result", 32'(ex_result), 32'h0002);
        check("add_sext_cond", 32'(cond), 32'b0010);
        check("add_sext_valid", 32'(ex_valid), 32'h1);

        // Forwarded A, overflow into sign bit
        op_forward_a = 2'd1; data_mem_fwd = 16'h7FFF; op_alu_src_b = 2'd1;
        instruction_register = 16'h0001;
        issue(t);
        check("add_ovf_result", 32'(ex_result), 32'h8000);
        check("add_ovf_cond", 32'(cond), 32'b1001);

        // Multiply 0x1234 * 0x0100, then disturb the forwarding paths
        op_forward_a = 2'd0; op_mul = 1'b1; br = 16'h1234; op_alu_src_b = 2'd2; ar = 16'h0100;
        issue(t);
        op_forward_a = 2'd1; op_forward_b = 2'd2; data_mem_fwd = 16'hFFFF; data_wb_fwd = 16'hFFFF;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            if (ready !== 1'b0) check("ready_while_busy", 32'(ready), 32'h0);
            n++;
            @(posedge clock);
            #2;
        end
        check("mul_busy_cycles", 32'(n), 32'd16);
        check("mul_lo", 32'(ex_result), 32'h3400);
        check("mul_hi", 32'(mul_hi), 32'h0012);
        check("mul_valid", 32'(ex_valid), 32'h1);

        // Back-pressure hold for three cycles, accept on release
        stall_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #2;
            check("stall_valid_hold", 32'(ex_valid), 32'h1);
            check("stall_result_hold", 32'(ex_result), 32'h3400);
            check("stall_ready", 32'(ready), 32'h0);
        end
        stall_in = 1'b0;
        op_mul = 1'b0; op_forward_a = 2'd0; op_forward_b = 2'd0; op_alu = 4'b0001;
        br = 16'h0001; op_alu_src_b = 2'd1; instruction_register = 16'h0002;
        issue(t);
        check("release_accept_tries", 32'(t), 32'd1);
        check("sub_borrow_cond", 32'(cond), 32'b1010);

        // Output register and combinational ar forward
        op_output_update = 1'b1; op_forward_c = 2'd2; data_wb_fwd = 16'hBEEF;
        @(posedge clock);
        #2;
        op_output_update = 1'b0;
        check("data_for_output", 32'(data_for_output), 32'hBEEF);
        op_forward_c = 2'd1; data_mem_fwd = 16'h1357;
        #1;
        check("ar_fwd_mem", 32'(ar_fwd), 32'h1357);

        // Reset in the middle of a multiply
        op_forward_c = 2'd0; op_mul = 1'b1; br = 16'h00FF; op_alu_src_b = 2'd2; ar = 16'h0101;
        issue(t);
        repeat (4) begin
            @(posedge clock);
            #2;
        end
        reset = 1'b0;
        @(posedge clock);
        #2;
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_valid", 32'(ex_valid), 32'h0);
        check("abort_result", 32'(ex_result), 32'h0);
        check("abort_hi", 32'(mul_hi), 32'h0);
        check("abort_dfo", 32'(data_for_output), 32'h0);
        sb.delete();
        last_hi = 16'h0;
        reset = 1'b1;
        op_mul = 1'b0; op_alu = 4'b0000; br = 16'h0005; op_alu_src_b = 2'd1;
        instruction_register = 16'h0003;
        issue(t);
        check("post_reset_add", 32'(ex_result), 32'h0008);
        check("post_reset_valid", 32'(ex_valid), 32'h1);

        // Randomized traffic with random back-pressure
        stall_rand = 1'b1;
        repeat (300) begin
            rand_ops();
            issue(t);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clock);
                #2;
            end
        end
        stall_rand = 1'b0;
        @(posedge clock);
        #3;
        stall_in = 1'b0;
        n = 0;
        while (sb.size() > 0 && n < 200) begin
            @(posedge clock);
            n++;
        end
        @(negedge clock);
        check("drain_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
